sfx_sequencer: RTL
==================

// Module: sfx_sequencer
// PURPOSE
//  Sound-effect controller that sits in front of SN76477 and owns all of its configuration inputs.
//  Game/user logic pulses one of NREQ request lines; the block arbitrates by fixed priority.
//  It then plays the chosen effect as a ROM-stored sequence of timed steps.
//  Each step sets VCO1/VCO2/LFO frequency, the selects, LFO depth and mixer, and holds them for N ticks.
//  Output is silent (mixer=0) when idle. Runs on the 25 MHz prescaled clock, the same clock as SN76477.
// PARAMETERS
//  NREQ      4      number of requesters; index 0 has the highest priority
//  TICK_DIV  25000  clk cycles per step tick (1 ms at 25 MHz); must be >= 2
//  MAXSTEP   8      steps per effect; step index is 3 bits
// PORTS
//  clk          in   1     25 MHz clock
//  reset        in   1     synchronous, active-high reset
//  req          in   NREQ  one-cycle trigger pulses, one per effect id
//  busy         out  1     1 while in LOAD or PLAY
//  active_id    out  2     id of the effect being played (0 when idle)
//  vco1_freq    out  9     {rom.vco1[2:0],6'b0} to SN76477
//  vco2_freq    out  9     {rom.vco2[2:0],6'b0}
//  lfo_freq     out  10    {1'b1,rom.lfo[1:0],7'b0}
//  vco1_select  out  1     rom.sel[0]
//  vco2_select  out  1     rom.sel[1]
//  noise_select out  1     rom.sel[2]
//  lfo_shift    out  3     {1'b0,rom.shift,1'b0}
//  mixer        out  4     rom.mixer in PLAY; 4'b0 otherwise
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, tick_cnt=0, step=0, dur=0, busy=0, active_id=0, all config outputs 0.
//  pending[NREQ-1:0]: bit i is set on req[i] and cleared when id i is granted; set wins over clear for a different id.
//  Tick: tick_cnt counts 0..TICK_DIV-1 and wraps; tick=1 on the cycle where tick_cnt==TICK_DIV-1.
//   tick_cnt is free-running and is not reset by grants, so the first step may be up to 1 tick short.
//  winner = lowest set index of (pending | req).
//  FSM:
//   IDLE -> LOAD when winner exists.
//    active_id<=winner, step<=0, pending[winner] cleared, busy<=1.
//   LOAD (1 cycle): register ROM word (active_id, step) onto the outputs.
//    dur<=max(rom.dur,1). -> PLAY
//   PLAY: dur decrements on tick. On the tick where dur==1:
//    not rom.last and step<MAXSTEP-1 -> step+1, LOAD
//    otherwise (sequence done) -> if winner exists grant it (as from IDLE) and LOAD;
//     else IDLE with mixer<=0, busy<=0, active_id<=0.
//    In the IDLE case all other config outputs hold their last values.
//  Preemption: in PLAY, a winner with index < active_id grants it on the next edge.
//   step restarts at 0 and the state goes to LOAD.
//   The preempted effect is dropped (it is not re-queued).
//   Same-priority or lower requests stay pending until the sequence completes.
//  Retrigger: req[active_id] during PLAY sets pending; the effect replays after it completes.
//  Latency: req at cycle n -> LOAD at cycle n+1 -> outputs valid at cycle n+2 (idle case).
//  Config outputs change only on the LOAD->PLAY edge, so SN76477 never sees a partial step.
//  A reset in mid-effect returns to the reset values on the next edge; pending requests are discarded.
//  Step wrap: step never exceeds MAXSTEP-1; reaching it ends the sequence even if last=0.
// STRUCTURE
//  Shared package/header sfx_pkg.vh:
//   state encodings ST_IDLE/ST_LOAD/ST_PLAY
//   ROM word field offsets: vco1 3, vco2 3, lfo 2, sel 3, shift 1, mixer 4, dur 8, last 1 = 25 bits
//  Sub-module sfx_rom (combinational case ROM, address {id[1:0],step[2:0]}, 25-bit data).
//   Holds effects 0..3 (e.g. explosion, laser, coin, siren).
//   Unused addresses return mixer=0, dur=1, last=1.
//  Top sound_generator: switches can be muxed against this block's outputs later; noise_freq stays fixed.
// TESTING  (bench uses TICK_DIV=4 and a test ROM with known words)
//  1 reset held 3 cycles -> busy=0, mixer=0, all freq outputs 0, active_id=0.
//  2 req[2] pulse in IDLE -> busy=1 at the next edge.
//    Two cycles later the outputs equal the words for id2/step0; each step holds dur*4 cycles (+/- tick phase).
//    After the last step: mixer=0, busy=0.
//  3 req[3] and req[1] in the same cycle -> id1 plays first, then id3 plays with no idle gap.
//    pending returns to 0 at the end.
//  4 id2 playing, req[0] pulse -> active_id=0 within 1 cycle, step restarts at 0, id2 is never resumed.
//  5 id1 playing, req[3] pulse -> id1 runs to completion, then id3 plays.
//    A second req[1] during id1 causes one replay of id1 before id3.
//  6 ROM word with dur=0 -> step lasts 1 tick.
//    8-step effect with last=0 everywhere -> ends after step 7.
//    Reset asserted mid-PLAY -> reset values on the next edge.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect sequencer.
//   - FSM state encodings
//   - ROM word layout (25 bits: vco1, vco2, lfo, sel, shift, mixer, dur, last)
//   - helper to build a ROM word from its fields
package sfx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    typedef struct packed {
        logic [2:0] vco1;
        logic [2:0] vco2;
        logic [1:0] lfo;
        logic [2:0] sel;
        logic       shift;
        logic [3:0] mixer;
        logic [7:0] dur;
        logic       last;
    } rom_word_t;

    function automatic rom_word_t mk_word(
        input logic [2:0] vco1,
        input logic [2:0] vco2,
        input logic [1:0] lfo,
        input logic [2:0] sel,
        input logic       shift,
        input logic [3:0] mixer,
        input logic [7:0] dur,
        input logic       last
    );
        rom_word_t w;
        w.vco1  = vco1;
        w.vco2  = vco2;
        w.lfo   = lfo;
        w.sel   = sel;
        w.shift = shift;
        w.mixer = mixer;
        w.dur   = dur;
        w.last  = last;
        return w;
    endfunction

endpackage

// File: rtl/sfx_rom.sv
// Combinational effect ROM, addressed by {id, step}.
//   id    in   2   effect id (0 explosion, 1 laser, 2 coin, 3 siren)
//   step  in   3   step index within the effect
//   word  out  25  step word; unused addresses are silent, 1 tick, last
module sfx_rom
    import sfx_pkg::*;
(
    input  logic [1:0] id,
    input  logic [2:0] step,
    output rom_word_t  word
);

    always_comb begin
        word = mk_word(3'd0, 3'd0, 2'd0, 3'b000, 1'b0, 4'h0, 8'd1, 1'b1);
        case ({id, step})
            5'b00_000: word = mk_word(3'd5, 3'd2, 2'd1, 3'b101, 1'b1, 4'h9, 8'd2, 1'b0);
            5'b00_001: word = mk_word(3'd6, 3'd1, 2'd3, 3'b100, 1'b0, 4'h4, 8'd0, 1'b1);
            5'b01_000: word = mk_word(3'd1, 3'd3, 2'd0, 3'b001, 1'b0, 4'h3, 8'd1, 1'b0);
            5'b01_001: word = mk_word(3'd2, 3'd4, 2'd2, 3'b011, 1'b1, 4'h5, 8'd2, 1'b1);
            5'b10_000: word = mk_word(3'd7, 3'd7, 2'd3, 3'b111, 1'b1, 4'hf, 8'd2, 1'b0);
            5'b10_001: word = mk_word(3'd4, 3'd5, 2'd1, 3'b010, 1'b0, 4'h7, 8'd1, 1'b0);
            5'b10_010: word = mk_word(3'd3, 3'd0, 2'd2, 3'b110, 1'b1, 4'ha, 8'd1, 1'b1);
            // siren runs all eight slots with last=0; the step limit ends it
            5'b11_000: word = mk_word(3'd0, 3'd7, 2'd0, 3'b001, 1'b0, 4'h1, 8'd1, 1'b0);
            5'b11_001: word = mk_word(3'd1, 3'd6, 2'd1, 3'b010, 1'b1, 4'h2, 8'd1, 1'b0);
            5'b11_010: word = mk_word(3'd2, 3'd5, 2'd2, 3'b001, 1'b0, 4'h3, 8'd1, 1'b0);
            5'b11_011: word = mk_word(3'd3, 3'd4, 2'd3, 3'b010, 1'b1, 4'h4, 8'd1, 1'b0);
            5'b11_100: word = mk_word(3'd4, 3'd3, 2'd0, 3'b001, 1'b0, 4'h5, 8'd1, 1'b0);
            5'b11_101: word = mk_word(3'd5, 3'd2, 2'd1, 3'b010, 1'b1, 4'h6, 8'd1, 1'b0);
            5'b11_110: word = mk_word(3'd6, 3'd1, 2'd2, 3'b001, 1'b0, 4'h7, 8'd1, 1'b0);
            5'b11_111: word = mk_word(3'd7, 3'd0, 2'd3, 3'b010, 1'b1, 4'h8, 8'd1, 1'b0);
            default:   ;
        endcase
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer in front of the SN76477. Arbitrates one-cycle
// request pulses by fixed priority (index 0 highest) and plays the chosen
// effect as a sequence of ROM steps, each held for dur ticks.
//   clk, reset           clock, synchronous active-high reset
//   req[NREQ]            trigger pulses, one per effect id
//   busy, active_id      status of the effect being played
//   vco1_freq..mixer     SN76477 configuration, updated only on LOAD->PLAY
//
// state | meaning
// IDLE  | silent, waiting for a request
// LOAD  | ROM word for (active_id, step) is registered onto the outputs
// PLAY  | holding the current step until its dur ticks expire
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TICK_DIV = 25000,
    parameter int MAXSTEP  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic            busy,
    output logic [1:0]      active_id,
    output logic [8:0]      vco1_freq,
    output logic [8:0]      vco2_freq,
    output logic [9:0]      lfo_freq,
    output logic            vco1_select,
    output logic            vco2_select,
    output logic            noise_select,
    output logic [2:0]      lfo_shift,
    output logic [3:0]      mixer
);

    localparam int TICK_W = $clog2(TICK_DIV);

    logic [1:0]        state;
    logic [NREQ-1:0]   pending;
    logic [NREQ-1:0]   cand;
    logic [NREQ-1:0]   grant_mask;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        step;
    logic [7:0]        dur;
    logic [1:0]        win;
    logic              have_win;
    logic              tick;
    logic              step_end;
    logic              seq_done;
    logic              preempt;
    logic              grant;
    rom_word_t         rom_word;

    sfx_rom u_rom (
        .id   (active_id),
        .step (step),
        .word (rom_word)
    );

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    // Requests arriving this cycle compete alongside the pending ones.
    always_comb begin
        cand     = pending | req;
        have_win = |cand;
        win      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) win = 2'(i);
        end
    end

    assign grant_mask = NREQ'(1) << win;
    assign step_end   = (state == ST_PLAY) && tick && (dur == 8'd1);
    assign seq_done   = rom_word.last || (step == 3'(MAXSTEP - 1));
    assign preempt    = (state == ST_PLAY) && have_win && (win < active_id);
    assign grant      = have_win && ((state == ST_IDLE) || preempt || (step_end && seq_done));
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pending      <= '0;
            tick_cnt     <= '0;
            step         <= '0;
            dur          <= '0;
            active_id    <= '0;
            vco1_freq    <= '0;
            vco2_freq    <= '0;
            lfo_freq     <= '0;
            vco1_select  <= 1'b0;
            vco2_select  <= 1'b0;
            noise_select <= 1'b0;
            lfo_shift    <= '0;
            mixer        <= '0;
        end else begin
            // free-running: a grant does not realign the tick phase
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            pending  <= grant ? (cand & ~grant_mask) : cand;

            if (grant) begin
                state     <= ST_LOAD;
                active_id <= win;
                step      <= '0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_LOAD: begin
                        vco1_freq    <= {rom_word.vco1, 6'b0};
                        vco2_freq    <= {rom_word.vco2, 6'b0};
                        lfo_freq     <= {1'b1, rom_word.lfo, 7'b0};
                        vco1_select  <= rom_word.sel[0];
                        vco2_select  <= rom_word.sel[1];
                        noise_select <= rom_word.sel[2];
                        lfo_shift    <= {1'b0, rom_word.shift, 1'b0};
                        mixer        <= rom_word.mixer;
                        dur          <= (rom_word.dur == 8'd0) ? 8'd1 : rom_word.dur;
                        state        <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (tick) begin
                            if (dur == 8'd1) begin
                                if (!seq_done) begin
                                    step  <= step + 3'd1;
                                    state <= ST_LOAD;
                                end else begin
                                    // other config outputs keep their last values
                                    state     <= ST_IDLE;
                                    mixer     <= '0;
                                    active_id <= '0;
                                end
                            end else begin
                                dur <= dur - 8'd1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
